// File: rtl/key_debounce.sv
// key_debounce: two-flop synchroniser and per-key debouncer for the piano
// key inputs. A free-running prescaler produces a shared tick. A key's new
// level is accepted after DB_TICKS consecutive ticks of disagreement with
// the debounced state. Accepted transitions produce registered one-cycle
// press/release strobes and a change flag.
module key_debounce #(
    parameter int N_KEYS   = 8,
    parameter int TICK_DIV = 50000,
    parameter int DB_TICKS = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] keys,
    output logic [N_KEYS-1:0] chord,
    output logic [N_KEYS-1:0] press,
    output logic [N_KEYS-1:0] rel,    // release strobe; "release" is a reserved word
    output logic              chg
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(DB_TICKS) + 1;
    localparam logic [PW-1:0] PC_LAST  = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_TICKS - 1);

    logic [N_KEYS-1:0] s1;
    logic [N_KEYS-1:0] s;
    logic [PW-1:0]     pc;
    logic              tick;
    logic [CW-1:0]     cnt [N_KEYS];
    logic [N_KEYS-1:0] acc;

    // With TICK_DIV=1 PC_LAST is 0 and pc never leaves 0, so tick is stuck at 1.
    assign tick = (pc == PC_LAST);

    // Two-flop synchroniser for the asynchronous key levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s  <= '0;
        end else begin
            s1 <= keys;
            s  <= s1;
        end
    end

    // Free-running prescaler; key activity never restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (tick) begin
            pc <= '0;
        end else begin
            pc <= pc + PW'(1);
        end
    end

    // A key is accepted on the tick that would complete its DB_TICKS-th count.
    always_comb begin
        acc = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            acc[i] = (s[i] != chord[i]) && tick && (cnt[i] == CNT_LAST);
        end
    end

    // Per-key tick counters; any agreement wipes the count (no partial credit).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_KEYS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_KEYS; i++) begin
                if ((s[i] == chord[i]) || acc[i]) begin
                    cnt[i] <= '0;
                end else if (tick) begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // Debounced state and strobes all update on the acceptance edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chord <= '0;
            press <= '0;
            rel   <= '0;
            chg   <= 1'b0;
        end else begin
            chord <= chord ^ acc;
            press <= acc & s;
            rel   <= acc & ~s;
            chg   <= |acc;
        end
    end

endmodule
